// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
// Holds the FSM state encoding, the memory map constants and the byte-lane helper.
package mau_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STROBE,
      SETTLE,
      DONE
   } state_t;

   localparam int MEM_BYTES_DEF = 4096;
   localparam int IMG_BASE      = 100;
   localparam int KERNEL_BASE   = 0;
   localparam int WORD_W        = 32;
   localparam int BYTE_W        = 8;

   // Little-endian lane pick: idx 0 is the least significant byte of the word.
   function automatic logic [BYTE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        idx);
      return word[int'(idx)*BYTE_W +: BYTE_W];
   endfunction

endpackage

// File: rtl/mau_lane_asm.sv
// Byte-lane steering for the memory access unit.
// Picks the store byte for the current lane and merges a loaded byte into the partial load word.
module mau_lane_asm
   import mau_pkg::*;
#(
   parameter int N          = 32,
   parameter int DATA_WIDTH = 8
) (
   input  logic [N-1:0]          store_word,
   input  logic [1:0]            store_idx,
   output logic [DATA_WIDTH-1:0] store_lane,
   input  logic [N-1:0]          load_buf,
   input  logic [1:0]            load_idx,
   input  logic [DATA_WIDTH-1:0] load_byte,
   output logic [N-1:0]          load_word
);

   assign store_lane = lane_sel(store_word, store_idx);

   // Untouched lanes pass through, so a byte load stays zero-extended.
   always_comb begin
      load_word = load_buf;
      load_word[int'(load_idx)*DATA_WIDTH +: DATA_WIDTH] = load_byte;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Splits pipeline word/byte loads and stores into strobed single-byte memory accesses.
// The pipeline is stalled until the access completes; loads return the little-endian assembled word.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int N          = 32,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_BYTES  = MEM_BYTES_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   input  logic         req_write,
   input  logic         req_byte,
   input  logic [N-1:0] req_addr,
   input  logic [N-1:0] req_wdata,
   output logic         stall,
   output logic         rsp_valid,
   output logic         rsp_fault,
   output logic [N-1:0] rsp_rdata,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   output logic         mem_read_en,
   output logic         mem_write_en,
   input  logic [N-1:0] mem_rdata
);

   localparam logic [1:0] WORD_LAST = 2'(N/DATA_WIDTH - 1);

   state_t                state;
   state_t                next_state;
   logic [1:0]            idx;
   logic [1:0]            next_idx;
   logic [N-1:0]          req_addr_q;
   logic [N-1:0]          req_wdata_q;
   logic                  req_write_q;
   logic                  req_byte_q;
   logic [N-1:0]          load_buf;
   logic                  accept;
   logic                  new_fault;
   logic [1:0]            new_last;
   logic [1:0]            cur_last;
   logic [N:0]            end_addr;
   logic [N-1:0]          base_addr;
   logic [N-1:0]          base_wdata;
   logic                  op_write;
   logic [DATA_WIDTH-1:0] store_lane;
   logic [N-1:0]          load_word;
   logic                  unused_rdata_hi;

   assign accept   = (state == IDLE) && req_valid;
   assign new_last = req_byte ? 2'd0 : WORD_LAST;
   assign cur_last = req_byte_q ? 2'd0 : WORD_LAST;

   // One extra bit keeps addresses near the top of the address space from wrapping past the check.
   assign end_addr  = {1'b0, req_addr} + {{(N-1){1'b0}}, new_last};
   assign new_fault = (!req_byte && (req_addr[1:0] != 2'b00)) ||
                      (end_addr >= (N+1)'(MEM_BYTES));

   assign base_addr  = accept ? req_addr  : req_addr_q;
   assign base_wdata = accept ? req_wdata : req_wdata_q;
   assign op_write   = accept ? req_write : req_write_q;

   assign stall = (state != DONE) && ((state != IDLE) || req_valid);

   assign unused_rdata_hi = ^mem_rdata[N-1:DATA_WIDTH];

   mau_lane_asm #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane_asm (
      .store_word (base_wdata),
      .store_idx  (next_idx),
      .store_lane (store_lane),
      .load_buf   (load_buf),
      .load_idx   (idx),
      .load_byte  (mem_rdata[DATA_WIDTH-1:0]),
      .load_word  (load_word)
   );

   always_comb begin
      next_state = state;
      next_idx   = idx;
      case (state)
         IDLE: begin
            if (req_valid) begin
               next_idx   = 2'd0;
               next_state = new_fault ? DONE : STROBE;
            end
         end
         STROBE: next_state = SETTLE;
         SETTLE: begin
            if (idx == cur_last) begin
               next_state = DONE;
            end else begin
               next_idx   = idx + 2'd1;
               next_state = STROBE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request register: the latched copy drives the whole access once accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= 2'd0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_write_q <= 1'b0;
         req_byte_q  <= 1'b0;
         load_buf    <= '0;
      end else begin
         state <= next_state;
         idx   <= next_idx;
         if (accept) begin
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
            req_write_q <= req_write;
            req_byte_q  <= req_byte;
            load_buf    <= '0;
         end else if ((state == SETTLE) && !req_write_q) begin
            load_buf <= load_word;
         end
      end
   end

   // Outputs are registered from the next-state decode, so each strobe is high for exactly the STROBE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         rsp_valid    <= 1'b0;
         rsp_fault    <= 1'b0;
         rsp_rdata    <= '0;
      end else begin
         mem_read_en  <= (next_state == STROBE) && !op_write;
         mem_write_en <= (next_state == STROBE) && op_write;
         if (next_state == STROBE) begin
            mem_addr  <= base_addr + N'(next_idx);
            mem_wdata <= {{(N-DATA_WIDTH){1'b0}}, store_lane};
         end
         rsp_valid <= (next_state == DONE);
         rsp_fault <= accept && new_fault;
         if ((state == SETTLE) && !req_write_q && (idx == cur_last)) begin
            rsp_rdata <= load_word;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit around an edge-triggered byte memory model.
// Expected responses are queued when a request is driven and compared when rsp_valid arrives.
module tb_mem_access_unit;
   import mau_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic        req_byte = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        stall;
   logic        rsp_valid;
   logic        rsp_fault;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [31:0] mem_rdata = '0;

   typedef struct {
      logic        fault;
      logic        check_rdata;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] last_rdata = '0;
   int          passes = 0;
   int          fails = 0;
   int          checks = 0;
   int          both_hi = 0;
   int          consec = 0;
   int          rd_cycles = 0;
   int          wr_cycles = 0;
   logic        prev_strobe = 1'b0;
   logic [7:0]  mem [0:4095];

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_byte     (req_byte),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall        (stall),
      .rsp_valid    (rsp_valid),
      .rsp_fault    (rsp_fault),
      .rsp_rdata    (rsp_rdata),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .mem_rdata    (mem_rdata)
   );

   // Memory acts on the rising edge of its strobes, like the real data memory.
   always @(posedge mem_write_en) begin
      #1;
      mem[mem_addr[11:0]] = mem_wdata[7:0];
   end

   always @(posedge mem_read_en) begin
      #1;
      mem_rdata = {24'h0, mem[mem_addr[11:0]]};
   end

   always @(negedge clk) begin
      if (mem_read_en && mem_write_en) both_hi++;
      if ((mem_read_en || mem_write_en) && prev_strobe) consec++;
      prev_strobe = mem_read_en || mem_write_en;
      if (mem_read_en) rd_cycles++;
      if (mem_write_en) wr_cycles++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at the first negedge after the accept edge; that cycle counts as latency 1.
   task automatic check_output();
      int   cycles;
      logic stall_ok;
      exp_t e;
      cycles   = 1;
      stall_ok = 1'b1;
      while (!rsp_valid && cycles < 40) begin
         if (stall !== 1'b1) stall_ok = 1'b0;
         @(negedge clk);
         cycles++;
      end
      check("rsp_arrived", {31'b0, rsp_valid}, 32'd1);
      check("sb_nonempty", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("latency", 32'(cycles), 32'(e.lat));
         check("fault", {31'b0, rsp_fault}, {31'b0, e.fault});
         if (e.check_rdata) check("rdata", rsp_rdata, e.rdata);
      end
      check("stall_busy", {31'b0, stall_ok}, 32'd1);
      check("stall_done", {31'b0, stall}, 32'd0);
      @(negedge clk);
      check("pulse_one", {31'b0, rsp_valid}, 32'd0);
   endtask

   task automatic apply_stimulus(input logic wr, input logic by, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic exp_fault,
                                 input logic [31:0] load_exp, input int exp_lat);
      exp_t e;
      if (!wr && !exp_fault) last_rdata = load_exp;
      e.fault       = exp_fault;
      e.check_rdata = !exp_fault;
      e.rdata       = last_rdata;
      e.lat         = exp_lat;
      sb.push_back(e);
      @(negedge clk);
      req_write = wr;
      req_byte  = by;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      #1;
      check("stall_accept", {31'b0, stall}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_write = 1'($urandom_range(0, 1));
      req_byte  = 1'($urandom_range(0, 1));
      check_output();
   endtask

   initial begin
      int rd0;
      int wr0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[IMG_BASE]     = 8'hA5;
      mem[IMG_BASE + 1] = 8'h5A;
      mem[4092] = 8'h01;
      mem[4093] = 8'h02;
      mem[4094] = 8'h03;
      mem[4095] = 8'h04;

      #1 rst_n = 1'b0;
      #1;
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_strobes", {30'b0, mem_read_en, mem_write_en}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] byte load from image base");
      rd0 = rd_cycles;
      apply_stimulus(1'b0, 1'b1, 32'd100, 32'd0, 1'b0, 32'h0000_00A5, 3);
      check("byte_load_strobes", 32'(rd_cycles - rd0), 32'd1);

      $display("[TB] word store then word load");
      wr0 = wr_cycles;
      apply_stimulus(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'd0, 9);
      check("store_strobes", 32'(wr_cycles - wr0), 32'd4);
      check("mem20", {24'b0, mem[32'h20]}, 32'hEF);
      check("mem21", {24'b0, mem[32'h21]}, 32'hBE);
      check("mem22", {24'b0, mem[32'h22]}, 32'hAD);
      check("mem23", {24'b0, mem[32'h23]}, 32'hDE);
      apply_stimulus(1'b0, 1'b0, 32'h20, 32'd0, 1'b0, 32'hDEAD_BEEF, 9);

      $display("[TB] byte store truncates to one lane");
      apply_stimulus(1'b1, 1'b1, 32'h30, 32'h1234_5677, 1'b0, 32'd0, 3);
      check("mem30", {24'b0, mem[32'h30]}, 32'h77);
      check("mem31", {24'b0, mem[32'h31]}, 32'h00);

      $display("[TB] faulting requests");
      rd0 = rd_cycles;
      wr0 = wr_cycles;
      apply_stimulus(1'b0, 1'b0, 32'h21, 32'd0, 1'b1, 32'd0, 1);
      apply_stimulus(1'b0, 1'b1, 32'd4096, 32'd0, 1'b1, 32'd0, 1);
      apply_stimulus(1'b0, 1'b0, 32'd4093, 32'd0, 1'b1, 32'd0, 1);
      apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd0, 1);
      check("fault_no_read", 32'(rd_cycles - rd0), 32'd0);
      check("fault_no_write", 32'(wr_cycles - wr0), 32'd0);

      $display("[TB] top-of-memory accesses");
      apply_stimulus(1'b0, 1'b0, 32'd4092, 32'd0, 1'b0, 32'h0403_0201, 9);
      apply_stimulus(1'b0, 1'b1, 32'd4095, 32'd0, 1'b0, 32'h0000_0004, 3);

      $display("[TB] reset during a word store");
      for (int i = 200; i < 204; i++) mem[i] = 8'h00;
      @(negedge clk);
      req_write = 1'b1;
      req_byte  = 1'b0;
      req_addr  = 32'd200;
      req_wdata = 32'h1122_3344;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("midstore_strobe_hi", {31'b0, mem_write_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_drop_strobes", {30'b0, mem_read_en, mem_write_en}, 32'd0);
      check("rst_drop_stall", {31'b0, stall}, 32'd0);
      check("mem200", {24'b0, mem[200]}, 32'h44);
      check("mem201", {24'b0, mem[201]}, 32'h33);
      check("mem202", {24'b0, mem[202]}, 32'h00);
      check("mem203", {24'b0, mem[203]}, 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      last_rdata = '0;
      @(negedge clk);
      check("post_rst_stall", {31'b0, stall}, 32'd0);
      check("post_rst_strobes", {30'b0, mem_read_en, mem_write_en}, 32'd0);
      check("post_rst_rdata", rsp_rdata, 32'd0);

      $display("[TB] back-to-back with req_valid held");
      req_write = 1'b0;
      req_byte  = 1'b1;
      req_addr  = 32'd100;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_addr = 32'd101;
      repeat (2) @(negedge clk);
      check("b2b_first_valid", {31'b0, rsp_valid}, 32'd1);
      check("b2b_first_rdata", rsp_rdata, 32'h0000_00A5);
      check("b2b_done_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      check("b2b_idle_valid", {31'b0, rsp_valid}, 32'd0);
      check("b2b_idle_stall", {31'b0, stall}, 32'd1);
      check("b2b_idle_noread", {31'b0, mem_read_en}, 32'd0);
      last_rdata = 32'h0000_005A;
      sb.push_back('{fault: 1'b0, check_rdata: 1'b1, rdata: 32'h0000_005A, lat: 3});
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_second_read", {31'b0, mem_read_en}, 32'd1);
      check("b2b_second_addr", mem_addr, 32'd101);
      check_output();

      check("never_both_strobes", 32'(both_hi), 32'd0);
      check("never_consec_strobes", 32'(consec), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
